// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Contents:
//   - MMIO base address and register offsets (LED, TXDATA, STATUS, BAUDDIV)
//   - Default reset value for the baud divisor
//   - Transmit FSM state encoding
//   - Word-address decode helper
package mmio_pkg;

  localparam logic [15:0] MMIO_BASE         = 16'h7f00;
  localparam logic [15:0] OFF_LED           = 16'h0000;
  localparam logic [15:0] OFF_TXDATA        = 16'h0002;
  localparam logic [15:0] OFF_STATUS        = 16'h0004;
  localparam logic [15:0] OFF_BAUDDIV       = 16'h0006;
  localparam logic [15:0] RESET_DIV_DEFAULT = 16'd433;
  localparam int          STATUS_OVF_BIT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Registers are 16-bit words, so only address bits 15:1 take part in decode.
  function automatic logic addr_hit(input logic [14:0] word_addr,
                                    input logic [15:0] off);
    return word_addr == 15'((MMIO_BASE + off) >> 1);
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for transmission.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (empties the FIFO)
//   push_i, wdata_i  write request and data; accepted when not full or when
//                    a pop happens in the same cycle
//   pop_i            read request; ignored when empty
//   rdata_o          head-of-queue data (valid while not empty)
//   full_o, empty_o  occupancy flags
//   count_o          number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Registers (word addresses):
//   0x7f02 TXDATA  write odd byte lane pushes d_dout[7:0]; reads 0
//   0x7f04 STATUS  {count[7:0], 4'b0, overflow, busy, empty, full};
//                  writing odd lane with bit 3 set clears overflow
//   0x7f06 BAUDDIV divisor D, each bit lasts D+1 clocks; byte-lane writable
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   d_addr     CPU byte address
//   d_oe       read enable
//   d_we       byte enables: [0] -> bits 15:8, [1] -> bits 7:0
//   d_dout     CPU write data
//   d_din      read data, high impedance when not selected
//   txd        serial output, idle high
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] RESET_DIV  = RESET_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [1:0]  d_we,
  input  logic [15:0] d_dout,
  output logic [15:0] d_din,
  output logic        txd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic sel_tx, sel_st, sel_bd, sel_any;
  logic unused_addr_lsb;

  assign sel_tx  = addr_hit(d_addr[15:1], OFF_TXDATA);
  assign sel_st  = addr_hit(d_addr[15:1], OFF_STATUS);
  assign sel_bd  = addr_hit(d_addr[15:1], OFF_BAUDDIV);
  assign sel_any = sel_tx || sel_st || sel_bd;
  assign unused_addr_lsb = d_addr[0];

  logic push_req, clr_ovf, pop;
  logic fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  assign push_req = sel_tx && d_we[1];
  assign clr_ovf  = sel_st && d_we[1] && d_dout[STATUS_OVF_BIT];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .wdata_i (d_dout[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  tx_state_e   state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] divlat_q, divlat_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovf_q, ovf_d;
  logic        busy;

  assign busy = (state_q != ST_IDLE);

  // Divisor register: each byte lane updates independently.
  always_comb begin
    div_d = div_q;
    if (sel_bd && d_we[0]) div_d[15:8] = d_dout[15:8];
    if (sel_bd && d_we[1]) div_d[7:0]  = d_dout[7:0];
  end

  // A dropped push wins over a simultaneous clear.
  always_comb begin
    ovf_d = (push_req && fifo_full && !pop) || (ovf_q && !clr_ovf);
  end

  // Transmit FSM. The divisor is captured at frame start (divlat) so that
  // BAUDDIV writes mid-frame only affect the next frame.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    divlat_d = divlat_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          state_d  = ST_START;
          divlat_d = div_q;
          timer_d  = div_q;
          shift_d  = fifo_rdata;
        end
      end
      ST_START: begin
        if (timer_q == 16'd0) begin
          state_d  = ST_DATA;
          timer_d  = divlat_q;
          bitcnt_d = 3'd0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = divlat_q;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (timer_q == 16'd0) begin
          // Chain directly into the next frame so queued bytes leave no gap.
          if (!fifo_empty) begin
            pop      = 1'b1;
            state_d  = ST_START;
            divlat_d = div_q;
            timer_d  = div_q;
            shift_d  = fifo_rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      div_q    <= RESET_DIV;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    divlat_q <= divlat_d;
    shift_q  <= shift_d;
  end

  // Derived from state flops only, so reset forces the line high at once.
  always_comb begin
    txd = 1'b1;
    if (state_q == ST_START)     txd = 1'b0;
    else if (state_q == ST_DATA) txd = shift_q[0];
  end

  logic [15:0] rdata;

  always_comb begin
    rdata = 16'h0000;
    if (sel_st)      rdata = {8'(fifo_count), 4'b0000, ovf_q, busy, fifo_empty, fifo_full};
    else if (sel_bd) rdata = div_q;
  end

  assign d_din = (d_oe && sel_any) ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx.
module tb_mmio_uart_tx;

  localparam logic [15:0] A_TX   = 16'h7f02;
  localparam logic [15:0] A_ST   = 16'h7f04;
  localparam logic [15:0] A_BD   = 16'h7f06;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_addr;
  logic        d_oe;
  logic [1:0]  d_we;
  logic [15:0] d_dout;
  wire  [15:0] d_din;
  wire         txd;

  int total = 0;
  int bad   = 0;

  mmio_uart_tx dut (
    .clk    (clk),
    .rst    (rst),
    .d_addr (d_addr),
    .d_oe   (d_oe),
    .d_we   (d_we),
    .d_dout (d_dout),
    .d_din  (d_din),
    .txd    (txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Bus write: presented now, sampled at the next rising edge.
  task automatic wr(input logic [15:0] a, input logic [1:0] we, input logic [15:0] dt);
    d_addr = a; d_we = we; d_dout = dt;
    @(posedge clk); #1;
    d_we = 2'b00;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    d_addr = a; d_oe = 1'b1;
    #1;
    v = d_din;
    d_oe = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1; d_oe = 1'b0; d_we = 2'b00; d_addr = 16'h0000; d_dout = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL reset_status: got %h want %h", v, 16'h0002); end
    rd(A_BD, v); total++;
    if (v !== 16'h01b1) begin bad++; $display("FAIL reset_bauddiv: got %h want %h", v, 16'h01b1); end
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
    rd(A_TX, v); total++;
    if (v !== 16'h0000) begin bad++; $display("FAIL txdata_read: got %h want %h", v, 16'h0000); end
  endtask

  task automatic test_bauddiv_lanes();
    logic [15:0] v;
    wr(A_BD, 2'b01, 16'h12ff);
    rd(A_BD, v); total++;
    if (v !== 16'h12b1) begin bad++; $display("FAIL bd_high_lane: got %h want %h", v, 16'h12b1); end
    wr(A_BD, 2'b10, 16'hab34);
    rd(A_BD, v); total++;
    if (v !== 16'h1234) begin bad++; $display("FAIL bd_low_lane: got %h want %h", v, 16'h1234); end
  endtask

  task automatic test_frame();
    logic [15:0] v;
    logic [9:0]  exp_bits;
    exp_bits = 10'b1010101010;  // 0x55 framed: bit0 start, bit9 stop
    wr(A_BD, 2'b11, 16'd3);
    wr(A_TX, 2'b10, 16'h0055);
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL frame_push_edge: got %b want 1", txd); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      total++;
      if (txd !== exp_bits[i/4]) begin
        bad++; $display("FAIL frame_bit clk%0d: got %b want %b", i, txd, exp_bits[i/4]);
      end
    end
    rd(A_ST, v); total++;
    if (v[2] !== 1'b1) begin bad++; $display("FAIL frame_busy_last: got %b want 1", v[2]); end
    @(posedge clk); #1;
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL frame_idle_status: got %h want %h", v, 16'h0002); end
  endtask

  task automatic test_overflow();
    logic [15:0] v;
    int n;
    wr(A_BD, 2'b11, 16'd0);
    for (int i = 1; i <= 9; i++) wr(A_TX, 2'b10, 16'(i));
    rd(A_ST, v); total++;
    if (v !== 16'h0805) begin bad++; $display("FAIL ovf_full_status: got %h want %h", v, 16'h0805); end
    wr(A_TX, 2'b10, 16'h00ee);
    rd(A_ST, v); total++;
    if (v !== 16'h080d) begin bad++; $display("FAIL ovf_set_status: got %h want %h", v, 16'h080d); end
    n = 0;
    rd(A_ST, v);
    while (v[2] && n < 300) begin
      @(posedge clk); #1;
      n++;
      rd(A_ST, v);
    end
    total++;
    if (n !== 82) begin bad++; $display("FAIL ovf_drain_clocks: got %0d want %0d", n, 82); end
    rd(A_ST, v); total++;
    if (v !== 16'h000a) begin bad++; $display("FAIL ovf_sticky: got %h want %h", v, 16'h000a); end
    wr(A_ST, 2'b10, 16'h0008);
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL ovf_clear: got %h want %h", v, 16'h0002); end
  endtask

  task automatic test_even_lane_ignored();
    logic [15:0] v;
    wr(A_TX, 2'b01, 16'h00aa);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (txd !== 1'b1) begin bad++; $display("FAIL even_lane_txd clk%0d: got %b want 1", i, txd); end
    end
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL even_lane_status: got %h want %h", v, 16'h0002); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic [9:0]  f1, f2;
    logic        e;
    f1 = 10'b1101001010;  // 0xA5 framed
    f2 = 10'b1001111000;  // 0x3C framed
    wr(A_BD, 2'b11, 16'd1);
    wr(A_TX, 2'b10, 16'h00a5);
    wr(A_TX, 2'b10, 16'h003c);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      e = (i < 20) ? f1[i/2] : f2[(i-20)/2];
      total++;
      if (txd !== e) begin bad++; $display("FAIL b2b_bit clk%0d: got %b want %b", i, txd, e); end
    end
    @(posedge clk); #1;
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL b2b_idle_status: got %h want %h", v, 16'h0002); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] v;
    wr(A_BD, 2'b11, 16'd3);
    wr(A_TX, 2'b10, 16'h0000);
    wr(A_TX, 2'b10, 16'h0000);
    repeat (4) begin @(posedge clk); #1; end
    total++;
    if (txd !== 1'b0) begin bad++; $display("FAIL midrst_before: got %b want 0", txd); end
    rst = 1'b1;
    #1;
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL midrst_txd_now: got %b want 1", txd); end
    @(posedge clk); #1;
    rst = 1'b0;
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL midrst_status: got %h want %h", v, 16'h0002); end
    rd(A_BD, v); total++;
    if (v !== 16'h01b1) begin bad++; $display("FAIL midrst_bauddiv: got %h want %h", v, 16'h01b1); end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (txd !== 1'b1) begin bad++; $display("FAIL midrst_stays_idle: got %b want 1", txd); end
  endtask

  task automatic test_div_change();
    logic [15:0] v;
    logic        e;
    wr(A_BD, 2'b11, 16'd1);
    wr(A_TX, 2'b10, 16'h0000);
    @(posedge clk); #1;
    wr(A_BD, 2'b11, 16'd3);
    wr(A_TX, 2'b10, 16'h0000);
    for (int t = 3; t <= 60; t++) begin
      if (t > 3) begin @(posedge clk); #1; end
      e = (t <= 18) ? 1'b0 : (t <= 20) ? 1'b1 : (t <= 56) ? 1'b0 : 1'b1;
      total++;
      if (txd !== e) begin bad++; $display("FAIL divchg_bit t%0d: got %b want %b", t, txd, e); end
    end
    @(posedge clk); #1;
    rd(A_ST, v); total++;
    if (v !== 16'h0002) begin bad++; $display("FAIL divchg_idle: got %h want %h", v, 16'h0002); end
  endtask

  initial begin
    test_reset();
    test_bauddiv_lanes();
    test_frame();
    test_overflow();
    test_even_lane_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_div_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
